// File: rtl/cpu_run_ctrl_if.sv
// Board-side controls and CPU/RAM enable outputs of the run/step sequencer.
// The master drives the board inputs and the PC; the slave is the sequencer.
interface cpu_run_ctrl_if;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 32;

  logic             run_mode;
  logic             step_btn;
  logic             resume;
  logic [PC_W-1:0]  pc_in;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_valid;
  logic             mem_clk_en;
  logic             cpu_clk_en;
  logic             halted;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run_mode, step_btn, resume, pc_in, bp_addr, bp_valid,
    input  mem_clk_en, cpu_clk_en, halted, state_out, cycle_count
  );

  modport slave (
    input  run_mode, step_btn, resume, pc_in, bp_addr, bp_valid,
    output mem_clk_en, cpu_clk_en, halted, state_out, cycle_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer issuing paired RAM-then-CPU clock enables.
// Optional PC breakpoint halt is compiled in with the BREAKPOINT_EN macro.
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           aresetn,
  cpu_run_ctrl_if.slave  bus
);
  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned COUNT_W = 32;

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic               phase_q, phase_d;
  logic               mask_q, mask_d;
  logic               run_meta_q, run_s_q;
  logic               btn_meta_q, btn_s_q;
  logic               deb_lvl_q, deb_prev_q;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic [COUNT_W-1:0] cycle_count_q;
  logic               mem_en_c, cpu_en_c;
  logic               step_ev_c;
  logic               bp_hit_c;

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      run_meta_q <= bus.run_mode;
      run_s_q    <= run_meta_q;
      btn_meta_q <= bus.step_btn;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Level only follows the button after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      deb_lvl_q  <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      deb_prev_q <= deb_lvl_q;
      if (btn_s_q != deb_lvl_q) begin
        if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_lvl_q <= btn_s_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign step_ev_c = deb_lvl_q & ~deb_prev_q;

`ifdef BREAKPOINT_EN
  assign bp_hit_c = bus.bp_valid && (bus.pc_in == bus.bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bus.pc_in, bus.bp_addr, bus.bp_valid, bus.resume};
  assign bp_hit_c  = 1'b0;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_HALT;
      phase_q <= 1'b0;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  // Next state and enable decode; phase 1 always completes the pair begun in phase 0
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    mask_d   = mask_q;
    mem_en_c = 1'b0;
    cpu_en_c = 1'b0;
    case (state_q)
      S_HALT: begin
        phase_d = 1'b0;
        if (run_s_q) begin
          state_d = S_RUN;
        end else if (step_ev_c) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (!phase_q) begin
          mem_en_c = 1'b1;
          phase_d  = 1'b1;
        end else begin
          cpu_en_c = 1'b1;
          phase_d  = 1'b0;
          state_d  = run_s_q ? S_RUN : S_HALT;
        end
      end
      S_RUN: begin
        if (phase_q) begin
          cpu_en_c = 1'b1;
          phase_d  = 1'b0;
          if (!run_s_q) state_d = S_HALT;
        end else if (!run_s_q) begin
          state_d = S_HALT;
        end else if (bp_hit_c) begin
          state_d = S_BREAK;
        end else begin
          mem_en_c = 1'b1;
          phase_d  = 1'b1;
        end
      end
`ifdef BREAKPOINT_EN
      S_BREAK: begin
        if (mask_q) begin
          if (!phase_q) begin
            mem_en_c = 1'b1;
            phase_d  = 1'b1;
          end else begin
            cpu_en_c = 1'b1;
            phase_d  = 1'b0;
            mask_d   = 1'b0;
            state_d  = run_s_q ? S_RUN : S_HALT;
          end
        end else if (bus.resume || step_ev_c) begin
          mask_d  = 1'b1;
          phase_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = S_HALT;
        phase_d = 1'b0;
        mask_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cycle_count_q <= '0;
    end else if (cpu_en_c) begin
      cycle_count_q <= cycle_count_q + COUNT_W'(1);
    end
  end

  assign bus.mem_clk_en  = mem_en_c;
  assign bus.cpu_clk_en  = cpu_en_c;
  assign bus.halted      = (state_q == S_HALT) || (state_q == S_BREAK);
  assign bus.state_out   = state_q;
  assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4 and a tiny PC model.
module tb_cpu_run_ctrl;
  logic        clk;
  logic        aresetn;
  logic [31:0] pc_q;
  int          n_checks;
  int          n_errors;
  int          mem_total;
  int          cpu_total;
  int          pair_viol;
  logic        prev_mem;
  int          mem_snap;
  int          cpu_snap;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU stand-in: PC advances by 4 on each cpu enable
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) pc_q <= 32'd0;
    else if (bus.cpu_clk_en) pc_q <= pc_q + 32'd4;
  end
  assign bus.pc_in = pc_q;

  // Pulse bookkeeping and pairing rule, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_clk_en) mem_total++;
    if (bus.cpu_clk_en) cpu_total++;
    if (bus.mem_clk_en && bus.cpu_clk_en) pair_viol++;
    if (prev_mem && !bus.cpu_clk_en && aresetn) pair_viol++;
    prev_mem = bus.mem_clk_en && aresetn;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    mem_snap = mem_total;
    cpu_snap = cpu_total;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mem_total = 0;
    cpu_total = 0;
    pair_viol = 0;
    prev_mem  = 1'b0;
    aresetn   = 1'b0;
    bus.run_mode = 1'b0;
    bus.step_btn = 1'b0;
    bus.resume   = 1'b0;
    bus.bp_addr  = 32'h0000_000C;
    bus.bp_valid = 1'b0;

    // Reset state
    cycles(3);
    check("rst_state", 32'(bus.state_out), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd1);
    check("rst_enables", 32'({bus.mem_clk_en, bus.cpu_clk_en}), 32'd0);
    check("rst_count", bus.cycle_count, 32'd0);
    aresetn = 1'b1;
    cycles(5);
    check("idle_state", 32'(bus.state_out), 32'd0);

    // Short press and bounce must not step
    snap();
    bus.step_btn = 1'b1; cycles(1); bus.step_btn = 1'b0; cycles(1);
    for (int i = 0; i < 5; i++) begin
      bus.step_btn = 1'b1; cycles(1);
      bus.step_btn = 1'b0; cycles(1);
    end
    cycles(10);
    check("bounce_mem", 32'(mem_total - mem_snap), 32'd0);
    check("bounce_cpu", 32'(cpu_total - cpu_snap), 32'd0);

    // Steady press: one pair, event latency 2 + DEBOUNCE_CYCLES
    snap();
    bus.step_btn = 1'b1;
    cycles(7);
    check("step_state", 32'(bus.state_out), 32'd2);
    check("step_mem", 32'(bus.mem_clk_en), 32'd1);
    cycles(1);
    check("step_cpu", 32'(bus.cpu_clk_en), 32'd1);
    cycles(1);
    check("step_back_halt", 32'(bus.state_out), 32'd0);
    cycles(10);
    check("step_pairs", 32'(cpu_total - cpu_snap), 32'd1);
    check("step_count", bus.cycle_count, 32'd1);
    bus.step_btn = 1'b0;
    cycles(10);

    // Free run, dropped while at phase 1
    snap();
    bus.run_mode = 1'b1;
    cycles(3);
    check("run_state", 32'(bus.state_out), 32'd1);
    check("run_first_mem", 32'(bus.mem_clk_en), 32'd1);
    cycles(1);
    check("run_first_cpu", 32'(bus.cpu_clk_en), 32'd1);
    cycles(16);
    bus.run_mode = 1'b0;
    cycles(6);
    check("run1_state", 32'(bus.state_out), 32'd0);
    check("run1_mem", 32'(mem_total - mem_snap), 32'd10);
    check("run1_cpu", 32'(cpu_total - cpu_snap), 32'd10);
    check("run1_count", bus.cycle_count, 32'd11);

    // Free run, dropped at phase 0: halts with no extra enable
    snap();
    bus.run_mode = 1'b1;
    cycles(21);
    bus.run_mode = 1'b0;
    cycles(6);
    check("run2_state", 32'(bus.state_out), 32'd0);
    check("run2_mem", 32'(mem_total - mem_snap), 32'd10);
    check("run2_cpu", 32'(cpu_total - cpu_snap), 32'd10);
    check("run2_count", bus.cycle_count, 32'd21);

    // Reset right after mem enable abandons the pair
    snap();
    bus.step_btn = 1'b1;
    cycles(7);
    check("mid_mem", 32'(bus.mem_clk_en), 32'd1);
    aresetn = 1'b0;
    #1;
    check("mid_state", 32'(bus.state_out), 32'd0);
    bus.step_btn = 1'b0;
    cycles(1);
    check("mid_no_cpu", 32'(cpu_total - cpu_snap), 32'd0);
    check("mid_count", bus.cycle_count, 32'd0);
    cycles(2);
    aresetn = 1'b1;
    cycles(3);

`ifdef BREAKPOINT_EN
    // Halt before executing the instruction at bp_addr, then resume through it
    snap();
    bus.bp_valid = 1'b1;
    bus.run_mode = 1'b1;
    cycles(30);
    check("bp_state", 32'(bus.state_out), 32'd3);
    check("bp_halted", 32'(bus.halted), 32'd1);
    check("bp_cpu", 32'(cpu_total - cpu_snap), 32'd3);
    check("bp_pc", pc_q, 32'h0000_000C);
    bus.resume = 1'b1;
    cycles(1);
    bus.resume = 1'b0;
    check("resume_mem", 32'(bus.mem_clk_en), 32'd1);
    cycles(1);
    check("resume_cpu", 32'(bus.cpu_clk_en), 32'd1);
    cycles(1);
    check("resume_state", 32'(bus.state_out), 32'd1);
    bus.run_mode = 1'b0;
    cycles(8);
    check("bp_stop_state", 32'(bus.state_out), 32'd0);
    bus.bp_valid = 1'b0;
`else
    // Without the feature the breakpoint inputs are ignored
    bus.bp_valid = 1'b1;
    bus.run_mode = 1'b1;
    cycles(30);
    check("nobp_state", 32'(bus.state_out), 32'd1);
    check("nobp_pc_past", 32'(pc_q > 32'h0000_000C), 32'd1);
    bus.run_mode = 1'b0;
    cycles(8);
    check("nobp_stop_state", 32'(bus.state_out), 32'd0);
    bus.bp_valid = 1'b0;
`endif

    // Counter wrap from all-ones
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    cycles(1);
    release dut.cycle_count_q;
    cycles(1);
    check("wrap_preload", bus.cycle_count, 32'hFFFF_FFFF);
    bus.step_btn = 1'b1;
    cycles(15);
    check("wrap_count", bus.cycle_count, 32'd0);
    bus.step_btn = 1'b0;
    cycles(10);

    check("pair_rule", 32'(pair_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
